stochastic_deser_arbiter: RTL

//  Shares one stochastic_deserializer among NUM_REQ bitstream sources using round-robin arbitration.

---
 rtl/stochastic_deser_arbiter_if.sv | 46 ++++
 rtl/stochastic_deser_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stochastic_deser_arbiter_if.sv
// Bus bundle between the stochastic sources, the arbiter and the shared deserializer.
// Latency: none (wires only).
// Backpressure: none here; the arbiter paces sources with start/done pulses.
//
// Signals (arbiter view, modport master):
//   req[NUM_REQ]      in   level request per source
//   ser_in[NUM_REQ]   in   serial stochastic bit per source
//   start[NUM_REQ]    out  one-cycle pulse, owner streams from next cycle
//   grant[NUM_REQ]    out  one-hot owner, held START..DONE
//   done[NUM_REQ]     out  one-cycle pulse to owner when res_out updates
//   res_out[RES_W]    out  captured count
//   timeout_err       out  pulse alongside done on an aborted run
//   busy              out  arbiter not idle
//   deser_ready       out  opens a bitstream on the deserializer
//   deser_ser         out  muxed serial bit to the deserializer
//   deser_valid       in   deserializer result valid
//   deser_res[RES_W]  in   deserializer result
interface stochastic_deser_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int RES_W   = 10
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ser_in;
  logic [NUM_REQ-1:0] start;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [RES_W-1:0]   res_out;
  logic               timeout_err;
  logic               busy;
  logic               deser_ready;
  logic               deser_ser;
  logic               deser_valid;
  logic [RES_W-1:0]   deser_res;

  // Arbiter side.
  modport master (
    input  req, ser_in, deser_valid, deser_res,
    output start, grant, done, res_out, timeout_err, busy, deser_ready, deser_ser
  );

  // Environment side: sources plus deserializer.
  modport slave (
    output req, ser_in, deser_valid, deser_res,
    input  start, grant, done, res_out, timeout_err, busy, deser_ready, deser_ser
  );
endinterface

// File: rtl/stochastic_deser_arbiter.sv
// Round-robin share of one stochastic deserializer among NUM_REQ bitstream sources.
// Latency: req seen at edge E0 -> done pulse in the cycle after E0+1026 (1024-bit stream).
// Backpressure: requests are level-held; a new request waits until the arbiter is idle again.
//
// Ports:
//   clk   in  system clock, posedge
//   rst   in  asynchronous active-high reset; a reset mid-run aborts silently
//   bus   stochastic_deser_arbiter_if.master (requests, serial bits, start/grant/done,
//         result, timeout flag, busy, and the deserializer ready/ser/valid/res link)
module stochastic_deser_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RES_W   = 10,
  parameter int TIMEOUT = 2047
) (
  input  logic clk,
  input  logic rst,
  stochastic_deser_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] start_q;
  logic [NUM_REQ-1:0] done_q;
  logic               ready_q;
  logic               terr_q;
  logic               busy_q;
  logic [RES_W-1:0]   res_q;
  logic [CNT_W-1:0]   cnt_q;

  // Round-robin pick (next-state candidate for owner).
  logic               pick_vld_d;
  logic [IDX_W-1:0]   pick_idx_d;
  logic [IDX_W-1:0]   cand;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Search from ptr+1 upward with wrap. The loop walks offsets from the far end
  // toward ptr+1 so the last hit written is the one closest to ptr+1.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand       = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
      if (bus.req[cand]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      start_q <= '0;
      done_q  <= '0;
      ready_q <= 1'b0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      start_q <= '0;
      done_q  <= '0;
      ready_q <= 1'b0;
      terr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            owner_q <= pick_idx_d;
            grant_q <= onehot(pick_idx_d);
            start_q <= onehot(pick_idx_d);
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          // Pointer moves only once the grant is committed.
          ptr_q   <= owner_q;
          state_q <= S_ARM;
        end
        S_ARM: begin
          // deser_valid may still be left over from the previous stream here.
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (bus.deser_valid) begin
            res_q   <= bus.deser_res;
            done_q  <= grant_q;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            res_q   <= '0;
            done_q  <= grant_q;
            terr_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The serial path is live only while a stream can be in flight.
  logic live;
  assign live = (state_q == S_START) || (state_q == S_ARM) || (state_q == S_RUN);

  assign bus.deser_ser   = live ? bus.ser_in[owner_q] : 1'b0;
  assign bus.deser_ready = ready_q;
  assign bus.start       = start_q;
  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = busy_q;
  assign bus.res_out     = res_q;

  // Structural invariants of the owner/pulse outputs.
  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_done_owner   : assert property (@(posedge clk) disable iff (rst) (|done_q) |-> (done_q == grant_q));
  a_terr_done    : assert property (@(posedge clk) disable iff (rst) terr_q |-> (|done_q));
  a_busy_state   : assert property (@(posedge clk) disable iff (rst) busy_q == (state_q != S_IDLE));

endmodule
